// File: rtl/riscv_pkg.sv
// Shared constants, types and helpers for the ID-stage register file slice.
package riscv_pkg;

  localparam int XLEN            = 32;
  localparam int NREG            = 32;
  localparam int REG_IDX_W       = 5;
  localparam int DBG_REG_DEFAULT = 5;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  localparam reg_idx_t ZERO_REG = '0;

  // True when the write-back port is updating register idx this cycle.
  // x0 never hits, so callers fall through to the hardwired zero.
  function automatic logic wb_hits(input reg_idx_t idx, input logic we,
                                   input reg_idx_t rd);
    return we && (rd == idx) && (idx != ZERO_REG);
  endfunction

endpackage

// File: rtl/id_regread_regfile_2r1w.sv
// 32-entry architectural register file: one write port, two combinational
// read ports with write-first bypass, x0 hardwired to zero. A raw view of a
// single register is exported for the debug mirror in the parent.
module regfile_2r1w #(
  parameter int XLEN    = riscv_pkg::XLEN,
  parameter int NREG    = riscv_pkg::NREG,
  parameter int DBG_REG = riscv_pkg::DBG_REG_DEFAULT
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            we,
  input  logic [riscv_pkg::REG_IDX_W-1:0] waddr,
  input  logic [XLEN-1:0]                 wdata,
  input  logic [riscv_pkg::REG_IDX_W-1:0] raddr1,
  input  logic [riscv_pkg::REG_IDX_W-1:0] raddr2,
  output logic [XLEN-1:0]                 rdata1,
  output logic [XLEN-1:0]                 rdata2,
  output logic [XLEN-1:0]                 dbg_raw
);
  import riscv_pkg::*;

  logic [XLEN-1:0] regs_reg [NREG];

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        // x0 is a constant zero; writes to it are dropped.
        always_ff @(posedge clk) begin
          regs_reg[gi] <= '0;
        end
      end else begin : g_gpr
        // Commit a write-back aimed at this entry; reset clears it.
        always_ff @(posedge clk) begin
          if (rst) begin
            regs_reg[gi] <= '0;
          end else if (we && (waddr == reg_idx_t'(gi))) begin
            regs_reg[gi] <= wdata;
          end
        end
      end
    end
  endgenerate

  // Write-first read ports: a same-cycle write to the read index wins.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (wb_hits(raddr1, we, waddr)) begin
      rdata1 = wdata;
    end else if (raddr1 != ZERO_REG) begin
      rdata1 = regs_reg[raddr1];
    end
    if (wb_hits(raddr2, we, waddr)) begin
      rdata2 = wdata;
    end else if (raddr2 != ZERO_REG) begin
      rdata2 = regs_reg[raddr2];
    end
  end

  assign dbg_raw = regs_reg[DBG_REG];

endmodule

// File: rtl/id_regread.sv
// ID-stage operand read: register file plus the ID/EX operand register with
// flush > stall > advance priority, stale-operand refresh while stalled, and
// a registered mirror of one register for board-level debug output.
module id_regread #(
  parameter int XLEN    = riscv_pkg::XLEN,
  parameter int NREG    = riscv_pkg::NREG,
  parameter int DBG_REG = riscv_pkg::DBG_REG_DEFAULT
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wb_regwrite,
  input  logic [riscv_pkg::REG_IDX_W-1:0] wb_rd,
  input  logic [XLEN-1:0]                 wb_data,
  input  logic                            id_valid,
  input  logic [riscv_pkg::REG_IDX_W-1:0] rs1_id,
  input  logic [riscv_pkg::REG_IDX_W-1:0] rs2_id,
  input  logic                            stall,
  input  logic                            flush,
  output logic                            ex_valid,
  output logic [riscv_pkg::REG_IDX_W-1:0] rs1_ex,
  output logic [riscv_pkg::REG_IDX_W-1:0] rs2_ex,
  output logic [XLEN-1:0]                 rs1_data_ex,
  output logic [XLEN-1:0]                 rs2_data_ex,
  output logic [XLEN-1:0]                 dbg_data
);
  import riscv_pkg::*;

  logic [XLEN-1:0] op1, op2, dbg_raw;

  logic            ex_valid_reg,    ex_valid_next;
  reg_idx_t        rs1_ex_reg,      rs1_ex_next;
  reg_idx_t        rs2_ex_reg,      rs2_ex_next;
  logic [XLEN-1:0] rs1_data_reg,    rs1_data_next;
  logic [XLEN-1:0] rs2_data_reg,    rs2_data_next;
  logic [XLEN-1:0] dbg_reg,         dbg_next;

  regfile_2r1w #(
    .XLEN    (XLEN),
    .NREG    (NREG),
    .DBG_REG (DBG_REG)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (wb_regwrite),
    .waddr   (wb_rd),
    .wdata   (wb_data),
    .raddr1  (rs1_id),
    .raddr2  (rs2_id),
    .rdata1  (op1),
    .rdata2  (op2),
    .dbg_raw (dbg_raw)
  );

  // Next ID/EX contents: flush bubbles, stall holds (refreshing operands a
  // write-back just overwrote), otherwise capture the bypassed reads.
  always_comb begin
    ex_valid_next = ex_valid_reg;
    rs1_ex_next   = rs1_ex_reg;
    rs2_ex_next   = rs2_ex_reg;
    rs1_data_next = rs1_data_reg;
    rs2_data_next = rs2_data_reg;
    if (flush) begin
      ex_valid_next = 1'b0;
      rs1_ex_next   = '0;
      rs2_ex_next   = '0;
      rs1_data_next = '0;
      rs2_data_next = '0;
    end else if (stall) begin
      if (wb_hits(rs1_ex_reg, wb_regwrite, wb_rd)) begin
        rs1_data_next = wb_data;
      end
      if (wb_hits(rs2_ex_reg, wb_regwrite, wb_rd)) begin
        rs2_data_next = wb_data;
      end
    end else begin
      ex_valid_next = id_valid;
      rs1_ex_next   = rs1_id;
      rs2_ex_next   = rs2_id;
      rs1_data_next = op1;
      rs2_data_next = op2;
    end
  end

  // Debug mirror follows every write to the watched register, write-first.
  always_comb begin
    dbg_next = dbg_raw;
    if (wb_hits(reg_idx_t'(DBG_REG), wb_regwrite, wb_rd)) begin
      dbg_next = wb_data;
    end
  end

  // ID/EX and debug registers; reset beats any concurrent activity.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_reg <= 1'b0;
      rs1_ex_reg   <= '0;
      rs2_ex_reg   <= '0;
      rs1_data_reg <= '0;
      rs2_data_reg <= '0;
      dbg_reg      <= '0;
    end else begin
      ex_valid_reg <= ex_valid_next;
      rs1_ex_reg   <= rs1_ex_next;
      rs2_ex_reg   <= rs2_ex_next;
      rs1_data_reg <= rs1_data_next;
      rs2_data_reg <= rs2_data_next;
      dbg_reg      <= dbg_next;
    end
  end

  assign ex_valid    = ex_valid_reg;
  assign rs1_ex      = rs1_ex_reg;
  assign rs2_ex      = rs2_ex_reg;
  assign rs1_data_ex = rs1_data_reg;
  assign rs2_data_ex = rs2_data_reg;
  assign dbg_data    = dbg_reg;

endmodule
